// File: rtl/count_enable_ctrl.sv
// Push-button front end for the program counter: synchronise, debounce and
// edge-detect two buttons, then issue one-cycle ENABLE strobes in STEP or RUN mode.

module cec_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1, s2, db, db_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      db_prev <= db;
      // any sample agreeing with db restarts the stability window
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_prev;
endmodule

module count_enable_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_STEP,
  input  logic BTN_MODE,
  output logic ENABLE,
  output logic RUN
);
  localparam int NUM_BTN = 2;
  localparam int PW      = $clog2(TICK_DIV);

  typedef enum logic {ST_STEP = 1'b0, ST_RUN = 1'b1} state_t;

  logic [NUM_BTN-1:0] btn_raw, press;
  logic               step_press, mode_press;

  assign btn_raw    = {BTN_MODE, BTN_STEP};
  assign step_press = press[0];
  assign mode_press = press[1];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    cec_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK   (CLK),
      .RST   (RST),
      .btn   (btn_raw[g]),
      .press (press[g])
    );
  end

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          enable_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_STEP;
      presc  <= '0;
      ENABLE <= 1'b0;
    end else begin
      state  <= state_nxt;
      presc  <= presc_nxt;
      ENABLE <= enable_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (mode_press) state_nxt = (state == ST_STEP) ? ST_RUN : ST_STEP;
  end

  // a mode toggle swallows any step press or run tick in the same cycle
  always_comb begin
    enable_nxt = 1'b0;
    presc_nxt  = '0;
    if (!mode_press) begin
      if (state == ST_STEP) begin
        enable_nxt = step_press;
      end else begin
        enable_nxt = (presc == PW'(TICK_DIV - 1));
        presc_nxt  = enable_nxt ? '0 : presc + 1'b1;
      end
    end
  end

  assign RUN = (state == ST_RUN);
endmodule
